timestamp_capture: RTL and testbench

Consumer of the free-running cycle counter. It detects rising edges on an event strobe and captures the counter value at each edge. Captured timestamps are buffered in a small first-word-fall-through FIFO and presented downstream on a valid/ready interface. Overflow is reported through a sticky flag and a saturating drop counter, so software can see how many events were lost.

---
 rtl/timestamp_capture.sv | 95 +++++++++
 tb/tb_timestamp_capture.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/timestamp_capture.sv
// Captures the free-running counter on rising edges of event_in and queues the
// timestamps in a small first-word-fall-through FIFO with overflow accounting.
module timestamp_capture #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         count_in,
    input  logic                     event_in,
    input  logic                     enable,
    input  logic                     clr_overflow,
    output logic [WIDTH-1:0]         ts_data,
    output logic                     ts_valid,
    input  logic                     ts_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ts_overflow,
    output logic [7:0]               drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          event_prev_q, event_prev_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_count_q, drop_count_d;

    logic edge_det;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        edge_det = event_in & ~event_prev_q;
        pop      = (level_q != '0) & ts_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push     = edge_det & enable & ((level_q != FULL_LEVEL) | pop);
        drop     = edge_det & enable & (level_q == FULL_LEVEL) & ~pop;

        event_prev_d = event_in;
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d      = level_q + LW'(push) - LW'(pop);

        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (clr_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end
    end

    // event_prev resets high so a strobe held through reset is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            event_prev_q <= 1'b1;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            event_prev_q <= event_prev_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= count_in;
        end
    end

    assign ts_data     = mem_q[rd_ptr_q];
    assign ts_valid    = (level_q != '0);
    assign level       = level_q;
    assign ts_overflow = overflow_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_timestamp_capture.sv
// Table-driven bench for timestamp_capture with a queue scoreboard for captured timestamps.
module tb_timestamp_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] count_in;
    logic        event_in;
    logic        enable;
    logic        clr_overflow;
    logic [31:0] ts_data;
    logic        ts_valid;
    logic        ts_ready;
    logic [2:0]  level;
    logic        ts_overflow;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic        ev;
        logic        en;
        logic        rdy;
        logic        clr;
        logic [31:0] cnt;
        logic        cap;
        logic [2:0]  lvl;
        logic        ovf;
        logic [7:0]  drp;
    } vec_t;

    vec_t tbl [$];

    timestamp_capture #(.WIDTH(32), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .count_in     (count_in),
        .event_in     (event_in),
        .enable       (enable),
        .clr_overflow (clr_overflow),
        .ts_data      (ts_data),
        .ts_valid     (ts_valid),
        .ts_ready     (ts_ready),
        .level        (level),
        .ts_overflow  (ts_overflow),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ev, input logic en, input logic rdy, input logic clr,
                                input logic [31:0] cnt, input logic cap, input logic [2:0] lvl,
                                input logic ovf, input logic [7:0] drp);
        vec_t v;
        v.ev = ev; v.en = en; v.rdy = rdy; v.clr = clr; v.cnt = cnt;
        v.cap = cap; v.lvl = lvl; v.ovf = ovf; v.drp = drp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic check_status(input string tag, input logic [2:0] lvl, input logic ovf, input logic [7:0] drp);
        chk({tag, " level"}, 32'(level), 32'(lvl));
        chk({tag, " ts_valid"}, 32'(ts_valid), 32'(lvl != 3'd0));
        chk({tag, " ts_overflow"}, 32'(ts_overflow), 32'(ovf));
        chk({tag, " drop_count"}, 32'(drop_count), 32'(drp));
    endtask

    // Called at a negedge: drive inputs, score any pop this cycle, then check state after the edge.
    task automatic apply(input vec_t v, input string tag);
        logic [31:0] want;
        event_in     = v.ev;
        enable       = v.en;
        ts_ready     = v.rdy;
        clr_overflow = v.clr;
        count_in     = v.cnt;
        #1;
        if (ts_valid && v.rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s pop: got ts_data 0x%0h, expected no valid entry", tag, ts_data);
            end else begin
                want = exp_q.pop_front();
                $display("%s: pop ts_data=0x%0h expected 0x%0h", tag, ts_data, want);
                chk({tag, " ts_data"}, ts_data, want);
            end
        end
        if (v.cap) exp_q.push_back(v.cnt);
        @(negedge clk);
        check_status(tag, v.lvl, v.ovf, v.drp);
    endtask

    initial begin
        rst = 1'b1; event_in = 1'b1; enable = 1'b1; ts_ready = 1'b0;
        clr_overflow = 1'b0; count_in = 32'd0;
        #1;
        check_status("reset", 3'd0, 1'b0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        check_status("reset held", 3'd0, 1'b0, 8'd0);
        rst = 1'b0;

        //            ev   en   rdy  clr  cnt           cap  lvl  ovf  drp
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,32'd7,       1'b0,3'd0,1'b0,8'd0)); // high through reset
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'd8,       1'b0,3'd0,1'b0,8'd0));
        tbl.push_back(mk(1'b1,1'b1,1'b1,1'b0,32'd100,     1'b1,3'd1,1'b0,8'd0)); // single capture
        tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'd101,     1'b0,3'd0,1'b0,8'd0));
        tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,32'd200,     1'b0,3'd0,1'b0,8'd0)); // disabled edge
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'd201,     1'b0,3'd0,1'b0,8'd0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,32'd10,      1'b1,3'd1,1'b0,8'd0)); // fill and overflow
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'd11,      1'b0,3'd1,1'b0,8'd0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,32'd20,      1'b1,3'd2,1'b0,8'd0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'd21,      1'b0,3'd2,1'b0,8'd0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,32'd30,      1'b1,3'd3,1'b0,8'd0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'd31,      1'b0,3'd3,1'b0,8'd0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,32'd40,      1'b1,3'd4,1'b0,8'd0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'd41,      1'b0,3'd4,1'b0,8'd0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,32'd50,      1'b0,3'd4,1'b1,8'd1));
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'd51,      1'b0,3'd4,1'b1,8'd1));
        tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'd52,      1'b0,3'd3,1'b1,8'd1)); // drain
        tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'd53,      1'b0,3'd2,1'b1,8'd1));
        tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'd54,      1'b0,3'd1,1'b1,8'd1));
        tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'd55,      1'b0,3'd0,1'b1,8'd1));
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b1,32'd56,      1'b0,3'd0,1'b0,8'd0)); // clear
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,32'd1,       1'b1,3'd1,1'b0,8'd0)); // full + push/pop
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'd1,       1'b0,3'd1,1'b0,8'd0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,32'd2,       1'b1,3'd2,1'b0,8'd0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'd2,       1'b0,3'd2,1'b0,8'd0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,32'd3,       1'b1,3'd3,1'b0,8'd0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'd3,       1'b0,3'd3,1'b0,8'd0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,32'd4,       1'b1,3'd4,1'b0,8'd0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'd4,       1'b0,3'd4,1'b0,8'd0));
        tbl.push_back(mk(1'b1,1'b1,1'b1,1'b0,32'd5,       1'b1,3'd4,1'b0,8'd0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'd6,       1'b0,3'd3,1'b0,8'd0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'd6,       1'b0,3'd2,1'b0,8'd0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'd6,       1'b0,3'd1,1'b0,8'd0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'd6,       1'b0,3'd0,1'b0,8'd0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,32'hFFFFFFFF,1'b1,3'd1,1'b0,8'd0)); // counter wrap
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h00000000,1'b0,3'd1,1'b0,8'd0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,32'h00000000,1'b1,3'd2,1'b0,8'd0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'h00000001,1'b0,3'd1,1'b0,8'd0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,32'h00000002,1'b0,3'd0,1'b0,8'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Saturation: fill, then 300 dropped edges.
        for (int i = 0; i < 4; i++) begin
            apply(mk(1'b1,1'b1,1'b0,1'b0,32'(1000+i),1'b1,3'(i+1),1'b0,8'd0), "sat fill");
            apply(mk(1'b0,1'b1,1'b0,1'b0,32'd0,      1'b0,3'(i+1),1'b0,8'd0), "sat fill");
        end
        for (int i = 0; i < 300; i++) begin
            apply(mk(1'b1,1'b1,1'b0,1'b0,32'(2000+i),1'b0,3'd4,1'b1,8'((i+1 > 255) ? 255 : i+1)), "sat drop");
            apply(mk(1'b0,1'b1,1'b0,1'b0,32'd0,      1'b0,3'd4,1'b1,8'((i+1 > 255) ? 255 : i+1)), "sat drop");
        end
        chk("saturated drop_count", 32'(drop_count), 32'd255);
        apply(mk(1'b1,1'b1,1'b0,1'b1,32'd5000,1'b0,3'd4,1'b0,8'd0), "clr vs drop");
        apply(mk(1'b0,1'b1,1'b1,1'b0,32'd5001,1'b0,3'd3,1'b0,8'd0), "pop to three");

        // Asynchronous reset mid-operation, away from any clock edge.
        #2;
        rst = 1'b1;
        event_in = 1'b0;
        #1;
        check_status("async reset", 3'd0, 1'b0, 8'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        apply(mk(1'b0,1'b1,1'b0,1'b0,32'd76,1'b0,3'd0,1'b0,8'd0), "post reset");
        apply(mk(1'b1,1'b1,1'b0,1'b0,32'd77,1'b1,3'd1,1'b0,8'd0), "post reset");
        apply(mk(1'b0,1'b1,1'b1,1'b0,32'd78,1'b0,3'd0,1'b0,8'd0), "post reset");

        chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
